// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit.
package rv32m_pkg;

  // funct3 encodings of the M extension
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide sharing one 64-bit accumulator, single-cycle write-back.
module mdu_iterative
  import rv32m_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned SELECTORS = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           funct3,
  input  logic [XLEN-1:0]      op_a,
  input  logic [XLEN-1:0]      op_b,
  input  logic [SELECTORS-1:0] rd_idx,
  output logic                 busy,
  output logic                 wb_en,
  output logic [SELECTORS-1:0] wb_idx,
  output logic [XLEN-1:0]      wb_data
);

  mdu_state_e             r_state;
  mdu_op_e                r_op;
  logic [SELECTORS-1:0]   r_idx;
  logic [XLEN-1:0]        r_m;
  logic [2*XLEN-1:0]      r_acc;
  logic [4:0]             r_cnt;
  logic                   r_neg_res;
  logic                   r_neg_rem;
  logic                   r_busy;
  logic                   r_wb_en;
  logic [SELECTORS-1:0]   r_wb_idx;
  logic [XLEN-1:0]        r_wb_data;

  mdu_op_e                w_op;
  logic                   w_a_neg;
  logic                   w_b_neg;
  logic [XLEN-1:0]        w_a_mag;
  logic [XLEN-1:0]        w_b_mag;
  logic                   w_div0;
  logic                   w_ovf;
  logic [XLEN-1:0]        w_special;

  logic [XLEN:0]          w_msum;
  logic [XLEN:0]          w_part;
  logic                   w_fit;
  logic [XLEN-1:0]        w_rem_next;
  logic [2*XLEN-1:0]      w_acc_next;
  logic [2*XLEN-1:0]      w_prod;
  logic [XLEN-1:0]        w_quot;
  logic [XLEN-1:0]        w_rem;
  logic [XLEN-1:0]        w_result;

  assign busy    = r_busy;
  assign wb_en   = r_wb_en;
  assign wb_idx  = r_wb_idx;
  assign wb_data = r_wb_data;

  // Accept-side decode: operand signs, magnitudes and division special cases
  always_comb begin
    w_op      = mdu_op_e'(funct3);
    w_a_neg   = op_a[XLEN-1] && ((w_op == OP_MULH) || (w_op == OP_MULHSU) ||
                                 (w_op == OP_DIV)  || (w_op == OP_REM));
    w_b_neg   = op_b[XLEN-1] && ((w_op == OP_MULH) || (w_op == OP_DIV) ||
                                 (w_op == OP_REM));
    w_a_mag   = w_a_neg ? -op_a : op_a;
    w_b_mag   = w_b_neg ? -op_b : op_b;
    w_div0    = funct3[2] && (op_b == '0);
    w_ovf     = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                (op_a == INT_MIN) && (op_b == '1);
    w_special = '0;
    if (w_div0)
      w_special = funct3[1] ? op_a : DIV0_QUOT;
    else if (w_ovf)
      w_special = funct3[1] ? '0 : INT_MIN;
  end

  // One iteration step plus final sign correction of the result
  always_comb begin
    // multiply: conditional add into the upper half, then shift right
    w_msum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_m} : '0);
    // divide: shift left, trial subtract with the bit shifted out kept
    w_part     = r_acc[2*XLEN-1:XLEN-1];
    w_fit      = (w_part >= {1'b0, r_m});
    w_rem_next = w_fit ? (w_part[XLEN-1:0] - r_m) : w_part[XLEN-1:0];
    if (r_op[2])
      w_acc_next = {w_rem_next, r_acc[XLEN-2:0], w_fit};
    else
      w_acc_next = {w_msum, r_acc[XLEN-1:1]};
    w_prod = r_neg_res ? -w_acc_next : w_acc_next;
    w_quot = r_neg_res ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
    w_rem  = r_neg_rem ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];
    case (r_op)
      OP_MUL:                     w_result = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU,
      OP_MULHU:                   w_result = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            w_result = w_quot;
      default:                    w_result = w_rem;
    endcase
  end

  // Control FSM with registered busy and write-back outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_MUL;
      r_idx     <= '0;
      r_m       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_busy    <= 1'b0;
      r_wb_en   <= 1'b0;
      r_wb_idx  <= '0;
      r_wb_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wb_en <= 1'b0;
          if (start) begin
            r_op   <= w_op;
            r_idx  <= rd_idx;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            if (w_div0 || w_ovf) begin
              r_state <= ST_DONE;
              r_wb_en <= (rd_idx != '0);
              if (rd_idx != '0) begin
                r_wb_idx  <= rd_idx;
                r_wb_data <= w_special;
              end
            end else begin
              r_state   <= ST_CALC;
              r_neg_res <= w_a_neg ^ w_b_neg;
              r_neg_rem <= w_a_neg;
              if (funct3[2]) begin
                r_m   <= w_b_mag;
                r_acc <= {{XLEN{1'b0}}, w_a_mag};
              end else begin
                r_m   <= w_a_mag;
                r_acc <= {{XLEN{1'b0}}, w_b_mag};
              end
            end
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_state <= ST_DONE;
            r_wb_en <= (r_idx != '0);
            if (r_idx != '0) begin
              r_wb_idx  <= r_idx;
              r_wb_data <= w_result;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_wb_en <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_wb_en <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative using a write-back scoreboard.
module tb_mdu_iterative;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_idx;
  logic        busy;
  logic        wb_en;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t sb_q[$];

  mdu_iterative #(.XLEN(32), .SELECTORS(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .rd_idx  (rd_idx),
    .busy    (busy),
    .wb_en   (wb_en),
    .wb_idx  (wb_idx),
    .wb_data (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference behaviour of the M extension using native wide arithmetic
  function automatic logic [31:0] ref_mdu(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0]        p;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sa / sb;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return sa % sb;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
  endfunction

  // Issue one operation, wait for its write-back and check it against the scoreboard
  task automatic run_op(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_data, input int lat,
                        input string name);
    exp_t       e;
    int         n;
    int         bcnt;
    bit         seen;
    logic [31:0] held;
    e.idx  = rd;
    e.data = exp_data;
    e.lat  = lat;
    sb_q.push_back(e);
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    funct3 = f;
    op_a   = a;
    op_b   = b;
    rd_idx = rd;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    funct3 = 3'($urandom_range(0, 7));
    op_a   = $urandom;
    op_b   = $urandom;
    rd_idx = 5'($urandom_range(0, 31));
    n    = 0;
    bcnt = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) bcnt++;
      if (wb_en) seen = 1;
    end
    e = sb_q.pop_front();
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: wb_en not seen within %0d cycles", name, n);
    end else begin
      checks++;
      if (n !== e.lat) begin
        errors++;
        $display("FAIL %s latency: got %0d expected %0d", name, n, e.lat);
      end
      checks++;
      if (bcnt !== e.lat) begin
        errors++;
        $display("FAIL %s busy cycles: got %0d expected %0d", name, bcnt, e.lat);
      end
      checks++;
      if (wb_data !== e.data) begin
        errors++;
        $display("FAIL %s data: got %h expected %h", name, wb_data, e.data);
      end
      checks++;
      if (wb_idx !== e.idx) begin
        errors++;
        $display("FAIL %s idx: got %0d expected %0d", name, wb_idx, e.idx);
      end
    end
    held = e.data;
    @(negedge clk);
    checks++;
    if (wb_en !== 1'b0 || busy !== 1'b0 || wb_data !== held) begin
      errors++;
      $display("FAIL %s after wb: wb_en=%b busy=%b data=%h expected 0 0 %h",
               name, wb_en, busy, wb_data, held);
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b0;
    funct3 = '0;
    op_a   = '0;
    op_b   = '0;
    rd_idx = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, wb_en, wb_idx, wb_data} !== '0) begin
      errors++;
      $display("FAIL reset state: busy=%b wb_en=%b idx=%0d data=%h expected all 0",
               busy, wb_en, wb_idx, wb_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    run_op(3'd0, 32'd7, 32'd6, 5'd5, 32'd42, 33, "mul_7x6");
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000, 33, "mulh_m1");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 33, "mulhu_max");
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, 33, "mulhsu_m1x2");
  endtask

  task automatic test_div();
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 33, "div_m7_2");
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 33, "rem_m7_2");
    run_op(3'd5, 32'd100, 32'd7, 5'd12, 32'd14, 33, "divu_100_7");
    run_op(3'd7, 32'd100, 32'd7, 5'd13, 32'd2, 33, "remu_100_7");
  endtask

  task automatic test_special();
    run_op(3'd4, 32'd5, 32'd0, 5'd14, 32'hFFFF_FFFF, 1, "div_by0");
    run_op(3'd6, 32'd5, 32'd0, 5'd15, 32'd5, 1, "rem_by0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1, "div_ovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0, 1, "rem_ovf");
  endtask

  task automatic test_random();
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    for (int i = 0; i < 8; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
      rd = 5'($urandom_range(1, 31));
      run_op(f, a, b, rd, ref_mdu(f, a, b), ref_lat(f, a, b), "random");
    end
  endtask

  task automatic test_back_to_back();
    run_op(3'd5, 32'd100, 32'd7, 5'd20, 32'd14, 33, "b2b_first");
    run_op(3'd7, 32'd100, 32'd7, 5'd21, 32'd2, 33, "b2b_second");
  endtask

  task automatic test_rd0_ignore_start();
    int n;
    int bcnt;
    int wcnt;
    funct3 = 3'd0;
    op_a   = 32'd3;
    op_b   = 32'd3;
    rd_idx = 5'd0;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    bcnt  = 0;
    wcnt  = 0;
    for (n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 10) begin
        funct3 = 3'd0;
        op_a   = 32'd1;
        op_b   = 32'd1;
        rd_idx = 5'd7;
        start  = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy) bcnt++;
      if (wb_en) wcnt++;
    end
    checks++;
    if (bcnt !== 33) begin
      errors++;
      $display("FAIL rd0 busy cycles: got %0d expected 33", bcnt);
    end
    checks++;
    if (wcnt !== 0) begin
      errors++;
      $display("FAIL rd0 wb_en pulses: got %0d expected 0", wcnt);
    end
  endtask

  task automatic test_reset_mid_op();
    int wcnt;
    funct3 = 3'd4;
    op_a   = 32'd1000;
    op_b   = 32'd3;
    rd_idx = 5'd22;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, wb_en, wb_idx, wb_data} !== '0) begin
      errors++;
      $display("FAIL mid-op reset: busy=%b wb_en=%b idx=%0d data=%h expected all 0",
               busy, wb_en, wb_idx, wb_data);
    end
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    wcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (wb_en || busy) wcnt++;
    end
    checks++;
    if (wcnt !== 0) begin
      errors++;
      $display("FAIL aborted op activity: got %0d active cycles expected 0", wcnt);
    end
    run_op(3'd0, 32'd2, 32'd3, 5'd9, 32'd6, 33, "mul_after_reset");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_random();
    test_back_to_back();
    test_rd0_ignore_start();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
